// File: rtl/qproj_seq.sv
// Purpose : sequencer for the Q-projection datapath: streams input x Wq words per tile,
//           captures each 512-bit result and writes it back as WPT 128-bit words.
// Latency : all pins registered (one cycle after state); mac_* trail the fetch pins by RD_LAT.
// Backpres: none on SRAMs; WAIT_ACC stalls on acc_valid. The external loader owns the SRAMs only in IDLE.
// Option  : define QSEQ_PERF_CNT_EN to build the saturating busy-cycle counter on perf_cycles.
module qproj_seq #(
    parameter int IN_WORDS  = 32,
    parameter int OUT_TILES = 32,
    parameter int WPT       = 4,
    parameter int RD_LAT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         ext_req,
    output logic         ext_gnt,
    output logic         busy,
    output logic         done,
    output logic         in_mem_ceb,
    output logic [4:0]   in_mem_addr,
    output logic         w_mem_ceb,
    output logic [9:0]   w_mem_addr,
    output logic         mac_en,
    output logic         mac_clr,
    output logic         mac_last,
    input  logic         acc_valid,
    input  logic [511:0] acc_data,
    output logic         out_mem_ceb,
    output logic         out_mem_web,
    output logic [6:0]   out_mem_addr,
    output logic [127:0] out_mem_din,
    output logic [31:0]  perf_cycles
);

    localparam int KW = $clog2(IN_WORDS);
    localparam int TW = $clog2(OUT_TILES);
    localparam int JW = $clog2(WPT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TW-1:0]    tile_q, tile_d;
    logic [JW-1:0]    j_q, j_d;
    logic             start_ok;
    logic [WPT*128-1:0] buf_q;

    logic             busy_q, done_q, ext_gnt_q;
    logic             in_ceb_q, w_ceb_q, out_ceb_q, out_web_q;
    logic [4:0]       in_addr_q;
    logic [9:0]       w_addr_q;
    logic [6:0]       out_addr_q;
    logic [127:0]     out_din_q;
    logic [RD_LAT:0]  en_pipe_q, clr_pipe_q, last_pipe_q;

    // Next-state and counter logic; counters clear at their terminal counts, never wrap.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        tile_d   = tile_q;
        j_d      = j_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                // ext_req (or a grant still held) beats a same-cycle start
                if (start && !ext_req && !ext_gnt_q) begin
                    start_ok = 1'b1;
                    state_d  = S_FETCH;
                    k_d      = '0;
                    tile_d   = '0;
                    j_d      = '0;
                end
            end
            S_FETCH: begin
                if (k_q == KW'(IN_WORDS - 1)) begin
                    k_d     = '0;
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (acc_valid) begin
                    j_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (j_q == JW'(WPT - 1)) begin
                    j_d = '0;
                    if (tile_q == TW'(OUT_TILES - 1)) begin
                        tile_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and counters; reset aborts a run at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            tile_q  <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tile_q  <= tile_d;
            j_q     <= j_d;
        end
    end

    // Result buffer: only the WAIT_ACC beat with acc_valid is captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q <= '0;
        end else if (state_q == S_WAIT && acc_valid) begin
            buf_q <= acc_data;
        end
    end

    // Registered SRAM and status pins driven from the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ext_gnt_q  <= 1'b0;
            in_ceb_q   <= 1'b1;
            w_ceb_q    <= 1'b1;
            out_ceb_q  <= 1'b1;
            out_web_q  <= 1'b1;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
            out_din_q  <= '0;
        end else begin
            // busy stays up through the final write pin and drops with the done pulse
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (state_q == S_DONE) begin
                busy_q <= 1'b0;
            end
            done_q     <= (state_q == S_DONE);
            ext_gnt_q  <= (state_q == S_IDLE) && ext_req;
            in_ceb_q   <= (state_q != S_FETCH);
            w_ceb_q    <= (state_q != S_FETCH);
            out_ceb_q  <= (state_q != S_WRITE);
            out_web_q  <= (state_q != S_WRITE);
            in_addr_q  <= 5'(k_q);
            w_addr_q   <= 10'(tile_q * IN_WORDS + k_q);
            out_addr_q <= 7'(tile_q * WPT + j_q);
            out_din_q  <= (state_q == S_WRITE) ? buf_q[128*j_q +: 128] : '0;
        end
    end

    // Operand strobes: stage 0 lines up with the fetch pins, the last stage with SRAM Q data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_pipe_q   <= '0;
            clr_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            en_pipe_q   <= {en_pipe_q[RD_LAT-1:0],   (state_q == S_FETCH)};
            clr_pipe_q  <= {clr_pipe_q[RD_LAT-1:0],  (state_q == S_FETCH) && (k_q == '0)};
            last_pipe_q <= {last_pipe_q[RD_LAT-1:0], (state_q == S_FETCH) && (k_q == KW'(IN_WORDS - 1))};
        end
    end

`ifdef QSEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared per accepted start, saturates, holds after done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (busy_q && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign ext_gnt      = ext_gnt_q;
    assign in_mem_ceb   = in_ceb_q;
    assign in_mem_addr  = in_addr_q;
    assign w_mem_ceb    = w_ceb_q;
    assign w_mem_addr   = w_addr_q;
    assign out_mem_ceb  = out_ceb_q;
    assign out_mem_web  = out_web_q;
    assign out_mem_addr = out_addr_q;
    assign out_mem_din  = out_din_q;
    assign mac_en       = en_pipe_q[RD_LAT];
    assign mac_clr      = clr_pipe_q[RD_LAT];
    assign mac_last     = last_pipe_q[RD_LAT];

endmodule

// File: tb/tb_qproj_seq.sv
// Bench for qproj_seq: random accumulator results, queue scoreboard for fetch and write traffic.
// A datapath model answers each mac_last with acc_valid three cycles later.
// Scenarios: reset/idle, arbitration, full run with disturbances, reset mid-write, rerun.
module tb_qproj_seq;

    logic         clk = 1'b0;
    logic         rst, start, ext_req, acc_valid;
    logic [511:0] acc_data;
    logic         ext_gnt, busy, done, in_mem_ceb, w_mem_ceb;
    logic [4:0]   in_mem_addr;
    logic [9:0]   w_mem_addr;
    logic         mac_en, mac_clr, mac_last;
    logic         out_mem_ceb, out_mem_web;
    logic [6:0]   out_mem_addr;
    logic [127:0] out_mem_din;
    logic [31:0]  perf_cycles;

`ifdef QSEQ_PERF_CNT_EN
    localparam logic [31:0] EXP_PERF = 32 * (32 + 1 + 3 + 1 + 4) + 1;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    typedef struct { logic [4:0] in_a; logic [9:0] w_a; } fetch_t;
    typedef struct { logic [6:0] addr; logic [127:0] dat; } wr_t;

    fetch_t fetch_q[$];
    wr_t    wr_q[$];
    fetch_t mf;
    wr_t    mw, dw;

    int errors = 0;
    int checks = 0;
    int fetch_cnt = 0, wr_cnt = 0, done_cnt = 0, mac_idx = 0;
    bit prev_fetch = 1'b0;
    int cd = 0, dp_tile = 0;

    always #5 clk = ~clk;

    qproj_seq dut (
        .clk(clk), .rst(rst), .start(start), .ext_req(ext_req), .ext_gnt(ext_gnt),
        .busy(busy), .done(done),
        .in_mem_ceb(in_mem_ceb), .in_mem_addr(in_mem_addr),
        .w_mem_ceb(w_mem_ceb), .w_mem_addr(w_mem_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
        .acc_valid(acc_valid), .acc_data(acc_data),
        .out_mem_ceb(out_mem_ceb), .out_mem_web(out_mem_web),
        .out_mem_addr(out_mem_addr), .out_mem_din(out_mem_din),
        .perf_cycles(perf_cycles)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference order of a full run: every tile reads words 0..IN_WORDS-1.
    task automatic push_run();
        fetch_t f;
        for (int t = 0; t < 32; t++) begin
            for (int k = 0; k < 32; k++) begin
                f.in_a = 5'(k);
                f.w_a  = 10'(t * 32 + k);
                fetch_q.push_back(f);
            end
        end
        fetch_cnt = 0;
        wr_cnt    = 0;
        done_cnt  = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents SRAM traffic or strobes.
    always @(negedge clk) begin
        if (!rst) begin
            fetch_q.delete();
            wr_q.delete();
            prev_fetch = 1'b0;
            mac_idx    = 0;
        end else begin
            if (busy) chk("gnt_while_busy", ext_gnt, 1'b0);
            if (ext_gnt) chk("ceb_while_gnt", {in_mem_ceb, w_mem_ceb, out_mem_ceb, out_mem_web}, 4'hF);
            if (!in_mem_ceb) begin
                chk("w_ceb_pair", w_mem_ceb, 1'b0);
                if (fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: w_addr %0d with nothing expected", w_mem_addr);
                end else begin
                    mf = fetch_q.pop_front();
                    chk("in_addr", in_mem_addr, mf.in_a);
                    chk("w_addr", w_mem_addr, mf.w_a);
                end
                fetch_cnt++;
            end
            if (mac_en || prev_fetch) chk("mac_en_align", mac_en, prev_fetch);
            if (mac_en) begin
                chk("mac_clr", mac_clr, (mac_idx % 32) == 0);
                chk("mac_last", mac_last, (mac_idx % 32) == 31);
                mac_idx++;
            end else if (mac_clr || mac_last) begin
                chk("strobe_without_en", {mac_clr, mac_last}, 2'b00);
            end
            if (!out_mem_ceb) begin
                chk("out_web", out_mem_web, 1'b0);
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: addr %0d with nothing expected", out_mem_addr);
                end else begin
                    mw = wr_q.pop_front();
                    chk("out_addr", out_mem_addr, mw.addr);
                    chk("out_din", out_mem_din, mw.dat);
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b0);
            end
            prev_fetch = !in_mem_ceb;
        end
    end

    // Datapath model: random junk on acc_data every cycle, a real result 3 cycles after mac_last.
    initial begin
        acc_valid = 1'b0;
        acc_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) acc_data[32*i +: 32] = $urandom;
            acc_valid = 1'b0;
            if (!rst) begin
                cd      = 0;
                dp_tile = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        acc_valid = 1'b1;
                        for (int j = 0; j < 4; j++) begin
                            dw.addr = 7'(dp_tile * 4 + j);
                            dw.dat  = acc_data[128*j +: 128];
                            wr_q.push_back(dw);
                        end
                        dp_tile++;
                    end
                end
                if (mac_last) cd = 3;
            end
        end
    end

    task automatic end_of_run_checks();
        chk("fetch_count", fetch_cnt, 1024);
        chk("write_count", wr_cnt, 128);
        chk("done_count", done_cnt, 1);
        chk("fetch_q_empty", fetch_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("perf_cycles", perf_cycles, EXP_PERF);
    endtask

    // Main stimulus
    initial begin
        bit seen;
        bit pulsed;
        rst = 1'b0;
        start = 1'b0;
        ext_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_gnt", ext_gnt, 1'b0);
        chk("rst_cebs", {in_mem_ceb, w_mem_ceb, out_mem_ceb, out_mem_web}, 4'hF);
        chk("rst_in_addr", in_mem_addr, 5'd0);
        chk("rst_w_addr", w_mem_addr, 10'd0);
        chk("rst_out_addr", out_mem_addr, 7'd0);
        chk("rst_din", out_mem_din, 128'd0);
        chk("rst_mac", {mac_en, mac_clr, mac_last}, 3'b000);
        chk("rst_perf", perf_cycles, 32'd0);

        // Arbitration: ext_req beats a same-cycle start
        start = 1'b1;
        ext_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arb_gnt", ext_gnt, 1'b1);
        chk("arb_busy", busy, 1'b0);
        ext_req = 1'b0;
        @(negedge clk);
        chk("arb_gnt_drop", ext_gnt, 1'b0);
        chk("arb_busy_idle", busy, 1'b0);

        // Run 1: start ignored at tile 3, ext_req held from tile 10
        push_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run1_busy", busy, 1'b1);
        seen = 1'b0;
        pulsed = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (fetch_cnt >= 3 * 32 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (fetch_cnt >= 10 * 32) ext_req = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL run1_timeout: no done within 3000 cycles");
        end
        chk("gnt_at_done", ext_gnt, 1'b0);
        @(negedge clk);
        chk("gnt_after_done", ext_gnt, 1'b1);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        end_of_run_checks();
        ext_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("perf_hold", perf_cycles, EXP_PERF);

        // Run 2: reset while writing word j=2 of tile 4
        push_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!out_mem_ceb && out_mem_addr == 7'd18) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL run2_timeout: write of tile 4 word 2 not seen");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_web", out_mem_web, 1'b1);
        chk("mid_rst_cebs", {in_mem_ceb, w_mem_ceb, out_mem_ceb}, 3'b111);
        chk("mid_rst_acc", acc_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Run 3: clean restart from tile 0
        push_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!in_mem_ceb) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL run3_no_fetch: fetch did not begin");
        end
        chk("restart_w_addr", w_mem_addr, 10'd0);
        chk("restart_in_addr", in_mem_addr, 5'd0);
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL run3_timeout: no done within 3000 cycles");
        end
        @(negedge clk);
        end_of_run_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qproj_seq.md
Name: qproj_seq

Overview:
- Sequencer for the Q-projection datapath and its three SRAMs: input (32x128), Wq (1024x128) and q_proj output (128x128).
- On start, streams all 32 input words against each of 32 weight tiles and drives operand-valid, clear and last strobes to the datapath.
- Captures each 512-bit result and writes it back as four 128-bit words.
- Arbitrates SRAM ownership between itself and the external init/fin loader.

Parameters:
IN_WORDS, 32, input words per tile (K depth)
OUT_TILES, 32, output tiles per run
WPT, 4, 128-bit output words per 512-bit result
RD_LAT, 1, SRAM read latency in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  run request pulse
ext_req  in  1  external loader requests SRAM ownership
ext_gnt  out  1  external loader owns SRAM muxes
busy  out  1  run in progress
done  out  1  one-cycle pulse after final write
in_mem_ceb  out  1  input SRAM chip enable, active-low
in_mem_addr  out  5  input SRAM address
w_mem_ceb  out  1  Wq SRAM chip enable, active-low
w_mem_addr  out  10  Wq SRAM address
mac_en  out  1  SRAM Q data valid to datapath
mac_clr  out  1  first operand of tile (with mac_en)
mac_last  out  1  last operand of tile (with mac_en)
acc_valid  in  1  datapath result valid
acc_data  in  512  datapath result
out_mem_ceb  out  1  output SRAM chip enable, active-low
out_mem_web  out  1  output SRAM write enable, active-low
out_mem_addr  out  7  output SRAM address
out_mem_din  out  128  output SRAM write data
perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (rst=0 at clk edge):
  - state IDLE; k, tile and j counters = 0.
  - busy=0, done=0, ext_gnt=0; all mac_* = 0.
  - all ceb=1, out_mem_web=1; all addresses and out_mem_din = 0.
  - Mid-run reset aborts immediately. No partial write is completed.
- Address decode: w_mem_addr = tile*IN_WORDS + k. in_mem_addr = k. out_mem_addr = tile*WPT + j.
- States:
  - IDLE:
    - ext_req=1 -> ext_gnt=1 (registered, one-cycle latency). Stays high while ext_req=1.
    - start=1 and ext_req=0 and ext_gnt=0 -> FETCH with tile=0, k=0, busy=1.
    - ext_req and start in the same cycle: ext_req wins; start is dropped.
  - FETCH:
    - in_mem_ceb=0 and w_mem_ceb=0 every cycle; k increments 0..IN_WORDS-1.
    - mac_en is the FETCH-cycle flag delayed RD_LAT cycles. mac_clr is aligned with k=0 data; mac_last is aligned with k=IN_WORDS-1 data.
    - After issuing k=IN_WORDS-1 -> WAIT_ACC.
  - WAIT_ACC:
    - SRAM ceb=1.
    - On acc_valid=1, acc_data is registered into a 512-bit buffer -> WRITE with j=0.
    - acc_valid is ignored in every other state.
  - WRITE:
    - out_mem_ceb=0, out_mem_web=0, out_mem_din = buf[128*j +: 128], for j = 0..WPT-1 (one word per cycle).
    - After j=WPT-1: tile=OUT_TILES-1 -> DONE; otherwise tile++, k=0 -> FETCH.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Boundaries:
  - start while busy: ignored.
  - ext_req while busy: ext_gnt held 0 until IDLE.
  - Counter wrap: k, tile and j never wrap mid-run; each is cleared at its terminal count.
  - While ext_gnt=1, all controller ceb=1 and web=1.
- Latency per tile: IN_WORDS + (datapath latency to acc_valid after mac_last) + 1 capture + WPT write cycles.

Optional Feature:
- Macro: QSEQ_PERF_CNT_EN.
- Defined: perf_cycles counts clk cycles with busy=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared on reset and on each accepted start.
  - Holds its value after done.
- Undefined: perf_cycles tied to 0; no counter flops.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> busy=0, done=0, all ceb=1, out_mem_web=1, addresses 0.
- Full run, acc_valid 3 cycles after mac_last, acc_data = {tile pattern}:
  - 128 output writes with out_mem_addr 0..127 in order.
  - Word 5 = acc_data[255:128] of tile 1.
  - done pulses once; perf_cycles = 32*(32+1+3+1+4) + 1 when the macro is defined.
- Address sweep: in tile 7, w_mem_addr runs 224..255 and in_mem_addr 0..31; mac_clr is high only on the first mac_en, mac_last only on the 32nd.
- Arbitration: ext_req=1 and start=1 in the same IDLE cycle -> ext_gnt=1 next cycle, busy stays 0. Drop ext_req, then pulse start -> run begins.
- Start and ext_req during run: pulse start at tile 3, assert ext_req at tile 10 -> no restart; ext_gnt rises only after done.
- Reset mid-WRITE: rst=0 at j=2 of tile 4 -> next cycle IDLE, out_mem_web=1. A new start begins at tile 0, w_mem_addr 0.
